alu_seq: RTL and testbench

Parametrised, registered successor to the 8-bit combinational ALU. It executes the existing single-cycle operations (ADD, SUB, NOR, SHFL, SHFR) and adds three iterative operations: shift-add multiply, shift-left-by-N and shift-right-by-N. Operands are captured on a start handshake. Results and flags are held in output registers until the next operation completes. The block sits between the ACC/REG datapath and the controller FSM, which waits on `alu_done` before sampling results.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ADD/SUB/NOR/SHFL/SHFR plus iterative MUL, SHLN and SHRN.
// Operands are captured on accept. Results and flags hold until the next completing edge.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_start,
    input  logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_a_in,
    input  logic [WIDTH-1:0] alu_b_in,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             alu_zero_flag,
    output logic             alu_carry_out,
    output logic             alu_busy,
    output logic             alu_done
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SHFL = 4'b1100;
    localparam logic [3:0] OP_SHFR = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_SHLN = 4'b0101;
    localparam logic [3:0] OP_SHRN = 4'b0110;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state, state_nxt;
    logic [3:0]       op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg, acc, mpl;

    logic [SHW-1:0]   amt;
    logic             accept, sc_valid, iter_start, sc_c, sh_c;
    logic [WIDTH-1:0] sc_out, sh_nxt, mul_acc_nxt, mul_mpl_nxt;
    logic [WIDTH:0]   mul_sum;

    assign amt      = alu_b_in[SHW-1:0];
    assign accept   = (state == IDLE) && alu_start;
    assign alu_busy = (state == EXEC);

    // Decode of the op presented at the accepting edge.
    always_comb begin
        sc_valid   = 1'b0;
        iter_start = 1'b0;
        sc_c       = 1'b0;
        sc_out     = '0;
        case (alu_select)
            OP_ADD: begin
                {sc_c, sc_out} = {1'b0, alu_a_in} + {1'b0, alu_b_in};
                sc_valid = 1'b1;
            end
            OP_SUB: begin
                {sc_c, sc_out} = {1'b0, alu_a_in} - {1'b0, alu_b_in};
                sc_valid = 1'b1;
            end
            OP_NOR: begin
                sc_out   = ~(alu_a_in | alu_b_in);
                sc_valid = 1'b1;
            end
            OP_SHFL: begin
                sc_out   = {alu_a_in[WIDTH-2:0], 1'b0};
                sc_c     = alu_a_in[WIDTH-1];
                sc_valid = 1'b1;
            end
            OP_SHFR: begin
                sc_out   = {1'b0, alu_a_in[WIDTH-1:1]};
                sc_c     = alu_a_in[0];
                sc_valid = 1'b1;
            end
            OP_MUL: iter_start = 1'b1;
            OP_SHLN, OP_SHRN: begin
                if (amt == '0) begin
                    sc_out   = alu_a_in;
                    sc_valid = 1'b1;
                end else begin
                    iter_start = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // One iteration step: shift-add multiply on {acc, mpl}, or a single-bit shift of acc.
    always_comb begin
        mul_sum     = {1'b0, acc} + (mpl[0] ? {1'b0, a_reg} : '0);
        mul_acc_nxt = mul_sum[WIDTH:1];
        mul_mpl_nxt = {mul_sum[0], mpl[WIDTH-1:1]};
        if (op == OP_SHLN) begin
            sh_nxt = {acc[WIDTH-2:0], 1'b0};
            sh_c   = acc[WIDTH-1];
        end else begin
            sh_nxt = {1'b0, acc[WIDTH-1:1]};
            sh_c   = acc[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && iter_start) state_nxt = EXEC;
            EXEC: if (cnt == CW'(1))        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op            <= '0;
            cnt           <= '0;
            a_reg         <= '0;
            acc           <= '0;
            mpl           <= '0;
            alu_out       <= '0;
            alu_out_hi    <= '0;
            alu_zero_flag <= 1'b0;
            alu_carry_out <= 1'b0;
            alu_done      <= 1'b0;
        end else begin
            alu_done <= 1'b0;
            if (accept) begin
                op    <= alu_select;
                a_reg <= alu_a_in;
                if (sc_valid) begin
                    alu_out       <= sc_out;
                    alu_out_hi    <= '0;
                    alu_carry_out <= sc_c;
                    alu_zero_flag <= ({sc_c, sc_out} == '0);
                    alu_done      <= 1'b1;
                end else if (iter_start) begin
                    if (alu_select == OP_MUL) begin
                        cnt <= CW'(WIDTH);
                        acc <= '0;
                        mpl <= alu_b_in;
                    end else begin
                        cnt <= CW'(amt);
                        acc <= alu_a_in;
                    end
                end else begin
                    // NOP / undefined: acknowledge only, results untouched.
                    alu_done <= 1'b1;
                end
            end else if (state == EXEC) begin
                cnt <= cnt - 1'b1;
                if (op == OP_MUL) begin
                    acc <= mul_acc_nxt;
                    mpl <= mul_mpl_nxt;
                    if (cnt == CW'(1)) begin
                        alu_out       <= mul_mpl_nxt;
                        alu_out_hi    <= mul_acc_nxt;
                        alu_carry_out <= |mul_acc_nxt;
                        alu_zero_flag <= ({mul_acc_nxt, mul_mpl_nxt} == '0);
                        alu_done      <= 1'b1;
                    end
                end else begin
                    acc <= sh_nxt;
                    if (cnt == CW'(1)) begin
                        alu_out       <= sh_nxt;
                        alu_out_hi    <= '0;
                        alu_carry_out <= sh_c;
                        alu_zero_flag <= ({sh_c, sh_nxt} == '0);
                        alu_done      <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with hand-computed expected values.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alu_start = 1'b0;
    logic [3:0] alu_select = 4'b0000;
    logic [7:0] alu_a_in = 8'h00;
    logic [7:0] alu_b_in = 8'h00;
    logic [7:0] alu_out, alu_out_hi;
    logic       alu_zero_flag, alu_carry_out, alu_busy, alu_done;

    int checks = 0;
    int failures = 0;
    int lat, bcnt, seen;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .alu_start(alu_start), .alu_select(alu_select),
        .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_out(alu_out),
        .alu_out_hi(alu_out_hi), .alu_zero_flag(alu_zero_flag),
        .alu_carry_out(alu_carry_out), .alu_busy(alu_busy), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present an op for one edge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        alu_select = sel; alu_a_in = a; alu_b_in = b; alu_start = 1'b1;
        @(negedge clk);
        alu_start = 1'b0;
    endtask

    // Count cycles (from the accepting edge) until done, and cycles busy was seen high.
    task automatic wait_done(output int l, output int b);
        l = 1; b = 0;
        while (!alu_done && l < 40) begin
            if (alu_busy) b++;
            @(negedge clk);
            l++;
        end
        if (alu_busy) b++;
    endtask

    task automatic check_res(input string tag, input logic [7:0] o, input logic [7:0] hi,
                             input logic c, input logic z);
        check({tag, ".out"}, alu_out, o);
        check({tag, ".hi"}, alu_out_hi, hi);
        check({tag, ".carry"}, alu_carry_out, c);
        check({tag, ".zero"}, alu_zero_flag, z);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_res("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset.busy", alu_busy, 0);
        check("reset.done", alu_done, 0);
        rst = 1'b0;

        // Async reset mid-cycle clears non-zero outputs without an edge
        issue(4'b0001, 8'h12, 8'h34);
        wait_done(lat, bcnt);
        check_res("pre_rst_add", 8'h46, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1; #1;
        check_res("async_rst", 8'h00, 8'h00, 1'b0, 1'b0);
        check("async_rst.done", alu_done, 0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (5) begin @(negedge clk); if (alu_done) seen++; end
        check("idle_no_done", seen, 0);

        // Single-cycle ops
        issue(4'b0001, 8'h80, 8'h80); wait_done(lat, bcnt);
        check("add.lat", lat, 1); check("add.busy", bcnt, 0);
        check_res("add", 8'h00, 8'h00, 1'b1, 1'b0);
        issue(4'b0010, 8'h05, 8'h05); wait_done(lat, bcnt);
        check_res("sub_eq", 8'h00, 8'h00, 1'b0, 1'b1);
        issue(4'b0010, 8'h03, 8'h05); wait_done(lat, bcnt);
        check_res("sub_borrow", 8'hFE, 8'h00, 1'b1, 1'b0);
        issue(4'b1011, 8'h01, 8'h00); wait_done(lat, bcnt);
        check_res("shfr", 8'h00, 8'h00, 1'b1, 1'b0);
        issue(4'b1100, 8'h81, 8'h00); wait_done(lat, bcnt);
        check_res("shfl", 8'h02, 8'h00, 1'b1, 1'b0);
        issue(4'b0011, 8'hF0, 8'h0C); wait_done(lat, bcnt);
        check_res("nor", 8'h03, 8'h00, 1'b0, 1'b0);

        // MUL
        issue(4'b0100, 8'hFF, 8'hFF); wait_done(lat, bcnt);
        check("mul_ff.lat", lat, 9); check("mul_ff.busy", bcnt, 8);
        check_res("mul_ff", 8'h01, 8'hFE, 1'b1, 1'b0);
        issue(4'b0100, 8'h00, 8'h37); wait_done(lat, bcnt);
        check_res("mul_zero", 8'h00, 8'h00, 1'b0, 1'b1);
        issue(4'b0100, 8'h0D, 8'h0B); wait_done(lat, bcnt);
        check_res("mul_small", 8'h8F, 8'h00, 1'b0, 1'b0);

        // Shift-by-N
        issue(4'b0101, 8'h81, 8'h03); wait_done(lat, bcnt);
        check("shln3.lat", lat, 4); check("shln3.busy", bcnt, 3);
        check_res("shln3", 8'h08, 8'h00, 1'b0, 1'b0);
        issue(4'b0110, 8'h81, 8'h00); wait_done(lat, bcnt);
        check("shrn0.lat", lat, 1); check("shrn0.busy", bcnt, 0);
        check_res("shrn0", 8'h81, 8'h00, 1'b0, 1'b0);
        issue(4'b0110, 8'h81, 8'h01); wait_done(lat, bcnt);
        check("shrn1.lat", lat, 2);
        check_res("shrn1", 8'h40, 8'h00, 1'b1, 1'b0);

        // Start while busy is ignored
        issue(4'b0100, 8'h10, 8'h03);
        @(negedge clk);
        alu_select = 4'b0001; alu_a_in = 8'h01; alu_b_in = 8'h01; alu_start = 1'b1;
        @(negedge clk); alu_start = 1'b0;
        wait_done(lat, bcnt);
        check("busy_ign.lat", lat, 7);
        check_res("busy_ign", 8'h30, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("busy_ign.no_2nd_done", alu_done, 0);
        check("busy_ign.hold", alu_out, 8'h30);

        // Back-to-back: start while done is high
        issue(4'b0001, 8'h01, 8'h02);
        check("b2b.done1", alu_done, 1); check("b2b.out1", alu_out, 8'h03);
        alu_select = 4'b0010; alu_a_in = 8'h09; alu_b_in = 8'h04; alu_start = 1'b1;
        @(negedge clk); alu_start = 1'b0;
        check("b2b.done2", alu_done, 1); check("b2b.out2", alu_out, 8'h05);

        // Abort a MUL with reset in its 4th EXEC cycle
        issue(4'b0100, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        check("abort.busy_before", alu_busy, 1);
        #2 rst = 1'b1; #1;
        check_res("abort", 8'h00, 8'h00, 1'b0, 1'b0);
        check("abort.busy", alu_busy, 0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (alu_done) seen++; end
        check("abort.no_done", seen, 0);

        // NOP and undefined opcode keep the prior result
        issue(4'b0001, 8'hF0, 8'h20); wait_done(lat, bcnt);
        check_res("hold_add", 8'h10, 8'h00, 1'b1, 1'b0);
        issue(4'b0000, 8'h00, 8'h00); wait_done(lat, bcnt);
        check("nop.lat", lat, 1);
        check_res("nop", 8'h10, 8'h00, 1'b1, 1'b0);
        issue(4'b1111, 8'h00, 8'h00); wait_done(lat, bcnt);
        check("undef.lat", lat, 1);
        check_res("undef", 8'h10, 8'h00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
